// File: rtl/bell202_pkg.sv
// Shared types and constants for the Bell202 transmit framer.
package bell202_pkg;

  localparam int   FRAME_W = 8;
  localparam logic MARK    = 1'b1;
  localparam logic SPACE   = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_HANG
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bell202_tx_framer_if.sv
// Host-side byte port plus NCO-side line outputs of the Bell202 transmit framer.
// Handshake: a byte on DATA_in is taken on any CLK edge where WR=1 and FULL=0;
// a WR while FULL=1 is dropped and answered by a one-cycle OVF pulse.
interface bell202_tx_framer_if;
  import bell202_pkg::*;

  logic [FRAME_W-1:0] DATA_in;
  logic               WR;
  logic               FULL;
  logic               OVF;
  logic               DATA;
  logic               DET;
  logic               BUSY;
  state_t             state;

  modport master (
    output DATA_in, WR,
    input  FULL, OVF, DATA, DET, BUSY, state
  );

  modport slave (
    input  DATA_in, WR,
    output FULL, OVF, DATA, DET, BUSY, state
  );

endinterface

// File: rtl/bell202_byte_fifo.sv
// Byte FIFO with combinational read of the head entry; full/empty are registered.
module bell202_byte_fifo
  import bell202_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [FRAME_W-1:0] din,
  input  logic               push,
  input  logic               pop,
  output logic [FRAME_W-1:0] dout,
  output logic               empty,
  output logic               full
);

  localparam int DEPTH = 1 << AW;

  logic [FRAME_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        cnt_q, cnt_d;
  logic               full_q, empty_q;
  logic               do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/bell202_tx_framer.sv
// Bell202 transmit framer: FIFO-buffered bytes sent as async frames with carrier keying.
// Build option BELL202_PARITY_EN inserts an even-parity bit before the stop bit.
module bell202_tx_framer
  import bell202_pkg::*;
#(
  parameter int BAUD_DIV      = 40,
  parameter int FIFO_AW       = 4,
  parameter int PREAMBLE_BITS = 32,
  parameter int HANG_BITS     = 16
) (
  input logic                CLK,
  input logic                RST,
  bell202_tx_framer_if.slave bus
);

  localparam int BW = cnt_w(BAUD_DIV);
  localparam int CW = cnt_w(max_int(max_int(PREAMBLE_BITS, HANG_BITS), FRAME_W));

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PREAMBLE_BITS - 1);
  localparam logic [CW-1:0] HANG_LAST = CW'(HANG_BITS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(FRAME_W - 1);

  state_t             state_q;
  logic [BW-1:0]      baud_q;
  logic [CW-1:0]      bit_q;
  logic [FRAME_W-1:0] shift_q;
  logic               data_q, det_q, ovf_q;
`ifdef BELL202_PARITY_EN
  logic               parity_q;
`endif

  logic [FRAME_W-1:0] fifo_dout;
  logic               fifo_empty, fifo_full;
  logic               tick, start_go;

  bell202_byte_fifo #(.AW(FIFO_AW)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .din   (bus.DATA_in),
    .push  (bus.WR),
    .pop   (start_go),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign tick = (baud_q == BAUD_LAST);

  // Every way into START is a bit boundary that also pops the next byte.
  always_comb begin
    start_go = 1'b0;
    if (tick) begin
      case (state_q)
        ST_PREAMBLE:     start_go = (bit_q == PRE_LAST);
        ST_STOP, ST_HANG: start_go = !fifo_empty;
        default:         start_go = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= MARK;
      det_q    <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef BELL202_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      ovf_q  <= bus.WR && fifo_full;
      // State changes only happen at ticks, so wrapping here also clears on entry.
      baud_q <= (state_q == ST_IDLE || tick) ? '0 : baud_q + BW'(1);
      if (start_go) begin
        state_q  <= ST_START;
        data_q   <= SPACE;
        shift_q  <= fifo_dout;
        bit_q    <= '0;
`ifdef BELL202_PARITY_EN
        parity_q <= ^fifo_dout;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!fifo_empty) begin
              state_q <= ST_PREAMBLE;
              det_q   <= 1'b1;
              bit_q   <= '0;
            end
          end
          ST_PREAMBLE: begin
            if (tick) bit_q <= bit_q + CW'(1);
          end
          ST_START: begin
            if (tick) begin
              state_q <= ST_DATA;
              data_q  <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= '0;
            end
          end
          ST_DATA: begin
            if (tick) begin
              if (bit_q == DATA_LAST) begin
`ifdef BELL202_PARITY_EN
                state_q <= ST_PARITY;
                data_q  <= parity_q;
`else
                state_q <= ST_STOP;
                data_q  <= MARK;
`endif
              end else begin
                data_q  <= shift_q[0];
                shift_q <= shift_q >> 1;
                bit_q   <= bit_q + CW'(1);
              end
            end
          end
`ifdef BELL202_PARITY_EN
          ST_PARITY: begin
            if (tick) begin
              state_q <= ST_STOP;
              data_q  <= MARK;
            end
          end
`endif
          ST_STOP: begin
            if (tick) begin
              state_q <= ST_HANG;
              data_q  <= MARK;
              bit_q   <= '0;
            end
          end
          ST_HANG: begin
            if (tick) begin
              if (bit_q == HANG_LAST) begin
                state_q <= ST_IDLE;
                det_q   <= 1'b0;
              end else begin
                bit_q <= bit_q + CW'(1);
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            data_q  <= MARK;
            det_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.DATA  = data_q;
  assign bus.DET   = det_q;
  assign bus.BUSY  = (state_q != ST_IDLE);
  assign bus.FULL  = fifo_full;
  assign bus.OVF   = ovf_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_bell202_tx_framer.sv
// Directed bench for bell202_tx_framer with small timing parameters.
module tb_bell202_tx_framer;
  import bell202_pkg::*;

  localparam int BAUD_DIV = 4;
  localparam int PRE_BITS = 2;
  localparam int HANG_BITS = 8;
`ifdef BELL202_PARITY_EN
  localparam int FRAME_LEN = 11;
`else
  localparam int FRAME_LEN = 10;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  bell202_tx_framer_if bus ();

  bell202_tx_framer #(
    .BAUD_DIV      (BAUD_DIV),
    .FIFO_AW       (4),
    .PREAMBLE_BITS (PRE_BITS),
    .HANG_BITS     (HANG_BITS)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return SPACE;
    if (k <= 8) return b[k-1];
`ifdef BELL202_PARITY_EN
    if (k == 9) return ^b;
`endif
    return MARK;
  endfunction

  // Checks every cycle of one frame starting at its first start-bit cycle.
  task automatic check_frame(input logic [7:0] b);
    for (int k = 0; k < FRAME_LEN; k++) begin
      for (int c = 0; c < BAUD_DIV; c++) begin
        check($sformatf("line_%02h_b%0d_c%0d", b, k, c), 32'(bus.DATA), 32'(exp_bit(b, k)));
        if (c == 0) check("det_in_frame", 32'(bus.DET), 32'(1));
        step();
      end
    end
  endtask

  task automatic check_next_frame();
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'(0), 32'(1));
    end else begin
      check_frame(exp_q.pop_front());
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.WR      = 1'b1;
    bus.DATA_in = b;
    step();
    bus.WR      = 1'b0;
  endtask

  task automatic wait_start(output int pre);
    int n;
    pre = 0;
    n   = 0;
    while (bus.DATA !== SPACE && n < 200) begin
      if (bus.DET === 1'b1) pre++;
      step();
      n++;
    end
    if (n >= 200) check("start_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.BUSY !== 1'b0 && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) check("idle_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pre, n;
    bus.WR      = 1'b0;
    bus.DATA_in = '0;
    RST         = 1'b1;
    repeat (3) step();
    RST = 1'b0;
    step();

    // Reset state
    check("rst_data", 32'(bus.DATA), 32'(1));
    check("rst_det",  32'(bus.DET),  32'(0));
    check("rst_busy", 32'(bus.BUSY), 32'(0));
    check("rst_full", 32'(bus.FULL), 32'(0));
    check("rst_ovf",  32'(bus.OVF),  32'(0));
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));

    // Single byte 0xA5 with exact latencies
    write_byte(8'hA5);
    check("det_after_1", 32'(bus.DET), 32'(0));
    step();
    check("det_after_2", 32'(bus.DET), 32'(1));
    check("busy_pre",    32'(bus.BUSY), 32'(1));
    for (int i = 0; i < PRE_BITS * BAUD_DIV; i++) begin
      check("preamble_mark", 32'(bus.DATA), 32'(1));
      step();
    end
    check_frame(8'hA5);
    for (int i = 0; i < HANG_BITS * BAUD_DIV; i++) begin
      check("hang_mark", 32'(bus.DATA), 32'(1));
      if (i == HANG_BITS * BAUD_DIV - 1) check("hang_det_last", 32'(bus.DET), 32'(1));
      step();
    end
    check("det_drop",  32'(bus.DET),  32'(0));
    check("busy_drop", 32'(bus.BUSY), 32'(0));

    // Back-to-back frames share one preamble
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    bus.WR = 1'b1; bus.DATA_in = 8'h00; step();
    bus.DATA_in = 8'hFF; step();
    bus.WR = 1'b0;
    wait_start(pre);
    check("b2b_preamble_len", pre, PRE_BITS * BAUD_DIV);
    check_next_frame();
    check_next_frame();
    wait_idle(n);
    check("b2b_hang_len", n, HANG_BITS * BAUD_DIV);

    // Overflow: 17 writes land while the first frame occupies the line
    exp_q.push_back(8'h5A);
    write_byte(8'h5A);
    wait_start(pre);
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          bus.WR      = 1'b1;
          bus.DATA_in = (8'(i) * 8'd37) ^ 8'hC3;
          if (i < 16) exp_q.push_back((8'(i) * 8'd37) ^ 8'hC3);
          step();
          check($sformatf("full_w%0d", i), 32'(bus.FULL), 32'(i >= 15));
          check($sformatf("ovf_w%0d", i),  32'(bus.OVF),  32'(i == 16));
        end
        bus.WR = 1'b0;
        step();
        check("ovf_once", 32'(bus.OVF), 32'(0));
      end
      begin
        for (int f = 0; f < 17; f++) check_next_frame();
      end
    join
    check("ovf_all_sent", exp_q.size(), 0);
    wait_idle(n);

    // Hang re-trigger during hang bit 5
    write_byte(8'h11);
    wait_start(pre);
    check_frame(8'h11);
    for (int i = 0; i < 5 * BAUD_DIV; i++) begin
      check("rt_hang_mark", 32'(bus.DATA), 32'(1));
      step();
    end
    check("rt_det_bit5", 32'(bus.DET), 32'(1));
    write_byte(8'h3C);
    for (int i = 1; i < BAUD_DIV; i++) begin
      check("rt_wait_mark", 32'(bus.DATA), 32'(1));
      check("rt_wait_det",  32'(bus.DET),  32'(1));
      step();
    end
    check_frame(8'h3C);
    wait_idle(n);
    check("rt_hang_len", n, HANG_BITS * BAUD_DIV);

`ifdef BELL202_PARITY_EN
    // Parity bit values
    write_byte(8'h07);
    wait_start(pre);
    check("par07_bit", 32'(exp_bit(8'h07, 9)), 32'(1));
    check_frame(8'h07);
    wait_idle(n);
    write_byte(8'h03);
    wait_start(pre);
    check_frame(8'h03);
    wait_idle(n);
`endif

    // Asynchronous reset mid-preamble discards everything
    bus.WR = 1'b1; bus.DATA_in = 8'h77; step();
    bus.DATA_in = 8'h88; step();
    bus.WR = 1'b0;
    check("pre_rst_det", 32'(bus.DET), 32'(1));
    step();
    step();
    #2;
    RST = 1'b1;
    #1;
    check("async_det",  32'(bus.DET),  32'(0));
    check("async_data", 32'(bus.DATA), 32'(1));
    check("async_full", 32'(bus.FULL), 32'(0));
    step();
    RST = 1'b0;
    step();
    check("post_rst_busy", 32'(bus.BUSY), 32'(0));
    repeat (20) step();
    check("post_rst_quiet_busy", 32'(bus.BUSY), 32'(0));
    check("post_rst_quiet_det",  32'(bus.DET),  32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
